// File: rtl/add_pipe_if.sv
// rtl/add_pipe_if.sv - valid/ready stream bundle for the pipelined adder
// Purpose: groups the operand stream into the adder and the result stream out of it.
// Signals:
//   in_valid, in_ready, a, b, cin      operand stream (producer -> adder)
//   out_valid, out_ready, sum, cout    result stream (adder -> consumer)
//   ovf                                signed overflow, present only with ADD_PIPE_OVF_EN
// Modports: slave = adder side, master = environment (producer + consumer) side.
interface add_pipe_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef ADD_PIPE_OVF_EN
   logic             ovf;
`endif

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout
`ifdef ADD_PIPE_OVF_EN
      , output ovf
`endif
   );

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout
`ifdef ADD_PIPE_OVF_EN
      , input ovf
`endif
   );
endinterface

// File: rtl/add_pipe.sv
// rtl/add_pipe.sv - pipelined, handshaked carry-chain adder
// Purpose: sum = a + b + cin (mod 2^WIDTH) computed over STAGES register stages,
//   one CHUNK = WIDTH/STAGES slice per stage; latency STAGES, throughput 1/cycle.
// Parameters: WIDTH (>= 1), STAGES (WIDTH % STAGES == 0).
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   add_pipe_if.slave: in_valid/in_ready/a/b/cin in, out_valid/out_ready/sum/cout out
// Option macro ADD_PIPE_OVF_EN: adds the registered signed-overflow output bus.ovf.
module add_pipe #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input logic       clk,
   input logic       rst,
   add_pipe_if.slave bus
);
   localparam int CHUNK = WIDTH / STAGES;

   if (WIDTH < 1 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
      $error("add_pipe: WIDTH must be >= 1 and an exact multiple of STAGES");
   end

   // Per-stage state: valid, carry out of this stage's chunk, sum so far, and the
   // operands carried forward so later stages can reach their chunks.
   logic             vld     [STAGES];
   logic             carry   [STAGES];
   logic [WIDTH-1:0] sum_r   [STAGES];
   logic [WIDTH-1:0] a_r     [STAGES];
   logic [WIDTH-1:0] b_r     [STAGES];

   logic             vld_n   [STAGES];
   logic             carry_n [STAGES];
   logic [WIDTH-1:0] sum_n   [STAGES];
   logic [WIDTH-1:0] a_n     [STAGES];
   logic [WIDTH-1:0] b_n     [STAGES];
   logic [CHUNK:0]   part_n  [STAGES];
   logic             adv;

   function automatic logic [CHUNK:0] add_chunk(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic             c,
                                                input int               k);
      return {1'b0, x[k*CHUNK +: CHUNK]} + {1'b0, y[k*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, c};
   endfunction

   // The whole pipe moves as one: it only stalls when a finished result is blocked.
   assign adv          = !vld[STAGES-1] || bus.out_ready;
   assign bus.in_ready = adv;

   always_comb begin
      vld_n[0]   = bus.in_valid;
      a_n[0]     = bus.a;
      b_n[0]     = bus.b;
      part_n[0]  = add_chunk(bus.a, bus.b, bus.cin, 0);
      sum_n[0]   = '0;
      sum_n[0][0 +: CHUNK] = part_n[0][CHUNK-1:0];
      carry_n[0] = part_n[0][CHUNK];
      for (int k = 1; k < STAGES; k++) begin
         vld_n[k]   = vld[k-1];
         a_n[k]     = a_r[k-1];
         b_n[k]     = b_r[k-1];
         part_n[k]  = add_chunk(a_r[k-1], b_r[k-1], carry[k-1], k);
         sum_n[k]   = sum_r[k-1];
         sum_n[k][k*CHUNK +: CHUNK] = part_n[k][CHUNK-1:0];
         carry_n[k] = part_n[k][CHUNK];
      end
   end

`ifdef ADD_PIPE_OVF_EN
   logic ovf_r;
   logic ovf_n;
   // a ^ b ^ sum at the MSB recovers the carry into the MSB; xor with cout gives overflow.
   always_comb begin
      ovf_n = a_n[STAGES-1][WIDTH-1] ^ b_n[STAGES-1][WIDTH-1]
            ^ sum_n[STAGES-1][WIDTH-1] ^ carry_n[STAGES-1];
   end
   assign bus.ovf = ovf_r;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            vld[k]   <= 1'b0;
            carry[k] <= 1'b0;
            sum_r[k] <= '0;
            a_r[k]   <= '0;
            b_r[k]   <= '0;
         end
`ifdef ADD_PIPE_OVF_EN
         ovf_r <= 1'b0;
`endif
      end else if (adv) begin
         for (int k = 0; k < STAGES; k++) begin
            vld[k]   <= vld_n[k];
            carry[k] <= carry_n[k];
            sum_r[k] <= sum_n[k];
            a_r[k]   <= a_n[k];
            b_r[k]   <= b_n[k];
         end
`ifdef ADD_PIPE_OVF_EN
         ovf_r <= ovf_n;
`endif
      end
   end

   assign bus.out_valid = vld[STAGES-1];
   assign bus.sum       = sum_r[STAGES-1];
   assign bus.cout      = carry[STAGES-1];
endmodule

// File: tb/tb_add_pipe.sv
// tb/tb_add_pipe.sv - self-checking bench for add_pipe (8b/2-stage and 16b/4-stage)
module tb_add_pipe;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   add_pipe_if #(.WIDTH(8))  bus8  ();
   add_pipe_if #(.WIDTH(16)) bus16 ();

   add_pipe #(.WIDTH(8),  .STAGES(2)) dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));
   add_pipe #(.WIDTH(16), .STAGES(4)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
   } vec_t;

   typedef struct {
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
   } exp_t;

   exp_t sb8[$];
   exp_t sb16[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   pops8    = 0;
   vec_t nil;
   vec_t tbl [13];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
      end
   endtask

   function automatic exp_t model16(input logic [15:0] a, input logic [15:0] b, input logic c);
      logic [16:0] s;
      exp_t        e;
      s      = {1'b0, a} + {1'b0, b} + {16'b0, c};
      e.sum  = s[15:0];
      e.cout = s[16];
      e.ovf  = (a[15] == b[15]) && (s[15] != a[15]);
      return e;
   endfunction

   // One clock of the 8-bit port: drive at negedge, resolve both handshakes, wait for the edge.
   task automatic step8(input logic valid, input vec_t t, input logic ordy, output logic acc);
      exp_t e;
      exp_t g;
      @(negedge clk);
      bus8.in_valid  = valid;
      bus8.a         = t.a;
      bus8.b         = t.b;
      bus8.cin       = t.cin;
      bus8.out_ready = ordy;
      #1;
      if (bus8.out_valid && bus8.out_ready) begin
         if (sb8.size() == 0) begin
            check("unexpected_out8", 32'(bus8.sum), 32'hDEAD);
         end else begin
            g = sb8.pop_front();
            pops8++;
            check("sum8",  32'(bus8.sum),  32'(g.sum));
            check("cout8", 32'(bus8.cout), 32'(g.cout));
`ifdef ADD_PIPE_OVF_EN
            check("ovf8",  32'(bus8.ovf),  32'(g.ovf));
`endif
         end
      end
      acc = valid && bus8.in_ready;
      if (acc) begin
         e.sum  = {8'h00, t.sum};
         e.cout = t.cout;
         e.ovf  = t.ovf;
         sb8.push_back(e);
      end
      @(posedge clk);
   endtask

   task automatic send8(input vec_t t, input logic ordy);
      logic acc;
      acc = 1'b0;
      for (int i = 0; i < 20 && !acc; i++) step8(1'b1, t, ordy, acc);
      if (!acc) check("accept_timeout8", 32'(acc), 32'd1);
   endtask

   task automatic drain8();
      logic acc;
      for (int i = 0; i < 40 && sb8.size() != 0; i++) step8(1'b0, nil, 1'b1, acc);
      check("drain_empty8", 32'(sb8.size()), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic acc;
      logic pend;
      int   p;
      exp_t g;

      nil = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
      //          a      b      cin   sum    cout  ovf
      tbl[0]  = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
      tbl[1]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
      tbl[2]  = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
      tbl[3]  = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[4]  = '{8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0};
      tbl[5]  = '{8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0};
      tbl[6]  = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
      tbl[7]  = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
      tbl[8]  = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
      tbl[9]  = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0};
      tbl[10] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};
      tbl[11] = '{8'hF0, 8'h20, 1'b0, 8'h10, 1'b1, 1'b0};
      tbl[12] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1};

      rst = 1'b1;
      bus8.in_valid  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.cin  = 1'b0; bus8.out_ready  = 1'b1;
      bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.out_ready = 1'b1;
      #12;
      check("rst_out_valid", 32'(bus8.out_valid), 32'd0);
      check("rst_sum",       32'(bus8.sum),       32'd0);
      check("rst_cout",      32'(bus8.cout),      32'd0);
      check("rst_in_ready",  32'(bus8.in_ready),  32'd1);
`ifdef ADD_PIPE_OVF_EN
      check("rst_ovf",       32'(bus8.ovf),       32'd0);
`endif
      @(negedge clk);
      rst = 1'b0;

      // Latency: accepted on edge t, visible after edge t+1.
      step8(1'b1, tbl[0], 1'b1, acc);
      check("lat_accept", 32'(acc), 32'd1);
      #1 check("lat_edge_t_valid", 32'(bus8.out_valid), 32'd0);
      step8(1'b0, nil, 1'b1, acc);
      #1 check("lat_edge_t1_valid", 32'(bus8.out_valid), 32'd1);
      check("lat_edge_t1_sum", 32'(bus8.sum), 32'h10);
      drain8();

      // Table sweep, one item per send.
      for (int i = 0; i < 13; i++) send8(tbl[i], 1'b1);
      drain8();

      // Back-to-back: four results must come out on four consecutive cycles.
      p = pops8;
      for (int i = 4; i < 8; i++) send8(tbl[i], 1'b1);
      step8(1'b0, nil, 1'b1, acc);
      step8(1'b0, nil, 1'b1, acc);
      check("b2b_consecutive", 32'(pops8 - p), 32'd4);
      drain8();

      // Stall: fill, then hold out_ready low for 5 cycles while C is offered.
      step8(1'b1, tbl[10], 1'b0, acc);
      check("stall_acc_a", 32'(acc), 32'd1);
      step8(1'b1, tbl[11], 1'b0, acc);
      check("stall_acc_b", 32'(acc), 32'd1);
      for (int i = 0; i < 5; i++) begin
         step8(1'b1, tbl[12], 1'b0, acc);
         check("stall_ignored", 32'(acc), 32'd0);
         #1;
         check("stall_in_ready",  32'(bus8.in_ready),  32'd0);
         check("stall_out_valid", 32'(bus8.out_valid), 32'd1);
         check("stall_sum",       32'(bus8.sum),       32'h30);
         check("stall_cout",      32'(bus8.cout),      32'd0);
      end
      send8(tbl[12], 1'b1);
      drain8();

      // Asynchronous reset with two items in flight.
      step8(1'b1, tbl[0], 1'b1, acc);
      step8(1'b1, tbl[11], 1'b1, acc);
      #1 check("pre_rst_valid", 32'(bus8.out_valid), 32'd1);
      bus8.in_valid = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("async_rst_valid", 32'(bus8.out_valid), 32'd0);
      check("async_rst_sum",   32'(bus8.sum),       32'd0);
      check("async_rst_cout",  32'(bus8.cout),      32'd0);
      sb8.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step8(1'b0, nil, 1'b1, acc);
         #1 check("no_stale_valid", 32'(bus8.out_valid), 32'd0);
      end
      send8(tbl[9], 1'b1);
      #1 check("post_rst_lat_t", 32'(bus8.out_valid), 32'd0);
      step8(1'b0, nil, 1'b1, acc);
      #1 check("post_rst_lat_t1", 32'(bus8.out_valid), 32'd1);
      check("post_rst_sum", 32'(bus8.sum), 32'h02);
      drain8();

      // 16-bit / 4-stage: random traffic and backpressure against the model.
      pend = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         bus16.out_ready = ($urandom_range(0, 3) != 0);
         if (!pend) begin
            bus16.in_valid = 1'($urandom_range(0, 1));
            bus16.a        = 16'($urandom);
            bus16.b        = 16'($urandom);
            bus16.cin      = 1'($urandom_range(0, 1));
         end
         #1;
         if (bus16.out_valid && bus16.out_ready) begin
            if (sb16.size() == 0) begin
               check("unexpected_out16", 32'(bus16.sum), 32'hDEAD);
            end else begin
               g = sb16.pop_front();
               check("sum16",  32'(bus16.sum),  32'(g.sum));
               check("cout16", 32'(bus16.cout), 32'(g.cout));
`ifdef ADD_PIPE_OVF_EN
               check("ovf16",  32'(bus16.ovf),  32'(g.ovf));
`endif
            end
         end
         if (bus16.in_valid && bus16.in_ready) begin
            sb16.push_back(model16(bus16.a, bus16.b, bus16.cin));
            pend = 1'b0;
         end else begin
            pend = bus16.in_valid;
         end
         @(posedge clk);
      end
      @(negedge clk);
      bus16.in_valid  = 1'b0;
      bus16.out_ready = 1'b1;
      for (int i = 0; i < 40 && sb16.size() != 0; i++) begin
         #1;
         if (bus16.out_valid) begin
            g = sb16.pop_front();
            check("sum16_drain",  32'(bus16.sum),  32'(g.sum));
            check("cout16_drain", 32'(bus16.cout), 32'(g.cout));
`ifdef ADD_PIPE_OVF_EN
            check("ovf16_drain",  32'(bus16.ovf),  32'(g.ovf));
`endif
         end
         @(negedge clk);
      end
      check("drain_empty16", 32'(sb16.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
